pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Free-running controller for the board PLL on the 50 MHz input clock.
- Sequences power-down and reset into the PLL.
- Qualifies the asynchronous lock output and releases the output dividers.
- Holds downstream logic in reset until the clocks are stable.
- Detects loss of lock, re-runs the bring-up with bounded retries, and reports status.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per bring-up attempt (>=2)
LOCK_TIMEOUT, 50000, max cycles from pll_rst release to qualified lock (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required to qualify lock
LOSS_FILT, 4, consecutive synchronized-lock-low cycles in RUN that count as lock loss (>=1)
RELEASE_DLY, 32, cycles between rstodiv deassert and sys_rst deassert
MAX_RETRIES, 3, timeouts tolerated before entering FAIL (1..15)

Ports:
clkin1  in  1  free-running 50 MHz reference clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
pll_lock  in  1  raw PLL LOCK; asynchronous to clkin1
restart  in  1  single-cycle request to re-run bring-up from any state
pll_pwd  out  1  PLL power-down
pll_rst  out  1  PLL reset
rstodiv  out  1  PLL output-divider reset
sys_rst  out  1  active-high reset for downstream logic; each consuming domain re-synchronizes it locally
ready  out  1  high only in RUN
fail  out  1  high only in FAIL
retry_cnt  out  4  timeouts since last RUN entry or restart
loss_cnt  out  8  lock-loss events since rst; saturates at 255
state  out  3  current state encoding, for debug

Behaviour:
- Reset values (rst=1): state RST_ASSERT, pll_pwd=0, pll_rst=1, rstodiv=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, loss_cnt=0, all counters 0.
- Lock synchronizer: pll_lock passes through two flops to give lock_s. Latency is 2 cycles. Raw pll_lock is never used elsewhere.
- Every output is a registered function of the state and counters; there are no combinational paths from the inputs.
- RST_ASSERT:
  - Outputs: pll_rst=1, rstodiv=1, sys_rst=1.
  - Exactly RST_CYCLES cycles, then go to WAIT_LOCK.
  - The timeout counter clears on exit.
- WAIT_LOCK:
  - Outputs: pll_rst=0, rstodiv=1.
  - The timeout counter increments each cycle.
  - lock_s=1 -> go to STABLE with the stable counter cleared.
- STABLE:
  - The timeout counter keeps running, so a glitchy lock cannot loop forever.
  - lock_s=0 -> go back to WAIT_LOCK.
  - STABLE_CYCLES consecutive lock_s=1 cycles -> go to RELEASE.
- Timeout: the timeout counter reaching LOCK_TIMEOUT in WAIT_LOCK or STABLE triggers it.
  - retry_cnt increments, saturating at 15.
  - If the new value is >= MAX_RETRIES, go to FAIL; otherwise go to RST_ASSERT.
- RELEASE:
  - Outputs: rstodiv=0 from the first cycle, sys_rst=1.
  - After RELEASE_DLY cycles, go to RUN.
  - lock_s=0 at any point -> go to RST_ASSERT. This counts as a loss event: loss_cnt increments.
- RUN:
  - Outputs: sys_rst=0, ready=1. retry_cnt clears on entry.
  - LOSS_FILT consecutive lock_s=0 cycles -> loss_cnt increments, go to RST_ASSERT. sys_rst and pll_rst rise on the same cycle the state changes.
  - A shorter low pulse resets the filter counter with no effect.
- FAIL:
  - Outputs: pll_pwd=1, pll_rst=1, rstodiv=1, sys_rst=1, fail=1.
  - Exits only on restart or rst.
- restart:
  - From any state, including RST_ASSERT (which restarts its count), go to RST_ASSERT on the next cycle.
  - Clears retry_cnt. Does not clear loss_cnt.
- Priority when events coincide: rst > restart > timeout > lock-based transitions.
- Counter widths: $clog2 of the largest of the parameters plus 1. Compare with >= so an overshoot cannot escape.

Decomposition:
- Package pll_sup_pkg holds:
  - the state enum (RST_ASSERT=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5);
  - localparam helpers for counter width.
- One sub-module: sync_2ff, a generic 2-flop bit synchronizer, reused by downstream domains for sys_rst.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=8, LOSS_FILT=3, RELEASE_DLY=4, MAX_RETRIES=2.
- Clean bring-up: rst released, pll_lock rises at cycle t -> pll_rst high exactly 4 cycles; rstodiv falls at t+10; sys_rst falls and ready rises at t+14; retry_cnt=0.
- Lock never asserts -> pll_rst re-pulses once after 64 cycles of WAIT_LOCK; after the second timeout fail=1, pll_pwd=1, retry_cnt=2; restart -> RST_ASSERT, retry_cnt=0, fail=0.
- Lock glitch in STABLE: lock low 1 cycle after 5 high cycles -> back to WAIT_LOCK; qualification restarts and needs 8 fresh cycles.
- In RUN, lock low 2 cycles -> no change, ready stays 1; lock low 3 cycles -> ready=0, sys_rst=1, pll_rst=1, loss_cnt=1.
- Lock drop during RELEASE -> RST_ASSERT, loss_cnt increments, sys_rst never deasserts.
- rst asserted mid-RUN -> next cycle all outputs hold their reset values and loss_cnt=0; 300 forced loss events -> loss_cnt holds at 255.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: state encoding, output bundle, counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RST_ASSERT = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RELEASE    = 3'd3,
        RUN        = 3'd4,
        FAIL       = 3'd5
    } pll_state_e;

    typedef struct packed {
        logic pll_pwd;
        logic pll_rst;
        logic rstodiv;
        logic sys_rst;
        logic ready;
        logic fail;
    } pll_out_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One spare bit above the largest limit so an incremented count can never wrap below it.
    function automatic int cnt_width(input int a, input int b, input int c, input int d, input int e);
        return $clog2(max2(max2(max2(a, b), max2(c, d)), e)) + 1;
    endfunction

    function automatic pll_out_t state_outputs(input pll_state_e s);
        pll_out_t o;
        o = '{pll_pwd: 1'b0, pll_rst: 1'b0, rstodiv: 1'b1, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};
        case (s)
            RST_ASSERT: o.pll_rst = 1'b1;
            RELEASE:    o.rstodiv = 1'b0;
            RUN: begin
                o.rstodiv = 1'b0;
                o.sys_rst = 1'b0;
                o.ready   = 1'b1;
            end
            FAIL: begin
                o.pll_pwd = 1'b1;
                o.pll_rst = 1'b1;
                o.fail    = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer.
// Latency: 2 cycles from d to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer: drives pwd/rst/divider reset, qualifies lock, gates sys_rst, retries on timeout.
// Latency: outputs registered from next state; lock seen 2 cycles after the pin via sync_2ff.
// Backpressure: none; free-running, restart honoured on any cycle.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOSS_FILT     = 4,
    parameter int RELEASE_DLY   = 32,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clkin1,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_pwd,
    output logic       pll_rst,
    output logic       rstodiv,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, LOSS_FILT, RELEASE_DLY);

    localparam logic [CW-1:0] RST_LIM    = CW'(RST_CYCLES);
    localparam logic [CW-1:0] TO_LIM     = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0] STABLE_LIM = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] LOSS_LIM   = CW'(LOSS_FILT);
    localparam logic [CW-1:0] REL_LIM    = CW'(RELEASE_DLY);
    localparam logic [3:0]    RETRY_LIM  = 4'(MAX_RETRIES);
    localparam pll_out_t      OUT_RST    = state_outputs(RST_ASSERT);

    logic lock_s;

    pll_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0]  to_cnt_q, to_cnt_d, to_inc;
    logic [3:0]     retry_q, retry_d, retry_sat;
    logic [7:0]     loss_q, loss_d;
    pll_out_t       out_q, out_d;
    logic           timeout, lost;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (clkin1),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // cnt_q is the per-state counter: reset hold, stable run, release delay, or loss filter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_cnt_d  = to_cnt_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        timeout   = 1'b0;
        lost      = 1'b0;
        cnt_inc   = cnt_q + CW'(1);
        to_inc    = to_cnt_q + CW'(1);
        retry_sat = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

        if (restart) begin
            state_d = RST_ASSERT;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                RST_ASSERT: begin
                    if (cnt_inc >= RST_LIM) begin
                        state_d  = WAIT_LOCK;
                        cnt_d    = '0;
                        to_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WAIT_LOCK: begin
                    to_cnt_d = to_inc;
                    if (to_inc >= TO_LIM) begin
                        timeout = 1'b1;
                    end else if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end
                end
                STABLE: begin
                    to_cnt_d = to_inc;
                    if (to_inc >= TO_LIM) begin
                        timeout = 1'b1;
                    end else if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_inc >= STABLE_LIM) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        lost = 1'b1;
                    end else if (cnt_inc >= REL_LIM) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                RUN: begin
                    if (lock_s) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= LOSS_LIM) begin
                        lost = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                FAIL: ;
                default: state_d = RST_ASSERT;
            endcase

            if (timeout) begin
                retry_d = retry_sat;
                state_d = (retry_sat >= RETRY_LIM) ? FAIL : RST_ASSERT;
                cnt_d   = '0;
            end

            if (lost) begin
                loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                state_d = RST_ASSERT;
                cnt_d   = '0;
            end
        end

        // Registering the next-state decode keeps outputs glitch-free and aligned with state_q.
        out_d = state_outputs(state_d);
    end

    always_ff @(posedge clkin1) begin
        if (rst) begin
            state_q  <= RST_ASSERT;
            cnt_q    <= '0;
            to_cnt_q <= '0;
            retry_q  <= '0;
            loss_q   <= '0;
            out_q    <= OUT_RST;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_cnt_q <= to_cnt_d;
            retry_q  <= retry_d;
            loss_q   <= loss_d;
            out_q    <= out_d;
        end
    end

    assign pll_pwd   = out_q.pll_pwd;
    assign pll_rst   = out_q.pll_rst;
    assign rstodiv   = out_q.rstodiv;
    assign sys_rst   = out_q.sys_rst;
    assign ready     = out_q.ready;
    assign fail      = out_q.fail;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed bring-up/loss/retry scenarios plus random lock traffic.
// A cycle-level reference model is compared against every output each cycle.
module tb_pll_lock_supervisor;

    localparam int P_RST  = 4;
    localparam int P_TO   = 64;
    localparam int P_STAB = 8;
    localparam int P_LOSS = 3;
    localparam int P_REL  = 4;
    localparam int P_MAXR = 2;

    localparam int S_RST  = 0;
    localparam int S_WAIT = 1;
    localparam int S_STAB = 2;
    localparam int S_REL  = 3;
    localparam int S_RUN  = 4;
    localparam int S_FAIL = 5;

    logic       clkin1   = 1'b0;
    logic       rst      = 1'b1;
    logic       pll_lock = 1'b0;
    logic       restart  = 1'b0;
    logic       pll_pwd, pll_rst, rstodiv, sys_rst, ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #10 clkin1 = ~clkin1;

    pll_lock_supervisor #(
        .RST_CYCLES    (P_RST),
        .LOCK_TIMEOUT  (P_TO),
        .STABLE_CYCLES (P_STAB),
        .LOSS_FILT     (P_LOSS),
        .RELEASE_DLY   (P_REL),
        .MAX_RETRIES   (P_MAXR)
    ) dut (
        .clkin1    (clkin1),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .restart   (restart),
        .pll_pwd   (pll_pwd),
        .pll_rst   (pll_rst),
        .rstodiv   (rstodiv),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt),
        .state     (state)
    );

    // Reference model: phase, time spent in phase, time since PLL reset release,
    // length of the current run of synchronized-low samples, and a 2-deep lock delay line.
    int m_st, m_age, m_since, m_lo_run, m_retry, m_loss;
    int m_dly[$];

    function automatic logic [5:0] exp_outs(input int s);
        // {pll_pwd, pll_rst, rstodiv, sys_rst, ready, fail}
        case (s)
            S_RST:         return 6'b011100;
            S_WAIT, S_STAB: return 6'b001100;
            S_REL:         return 6'b000100;
            S_RUN:         return 6'b000010;
            default:       return 6'b111101;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit rs, input bit lk);
        int ls;
        int nxt;
        bit to;
        bit lost;
        if (r) begin
            m_st = S_RST; m_age = 0; m_since = 0; m_lo_run = 0; m_retry = 0; m_loss = 0;
            m_dly.delete();
            m_dly.push_back(0);
            m_dly.push_back(0);
            return;
        end
        ls = m_dly.pop_front();
        m_dly.push_back(int'(lk));
        m_lo_run = (ls != 0) ? 0 : m_lo_run + 1;
        nxt  = m_st;
        to   = 1'b0;
        lost = 1'b0;
        if (rs) begin
            nxt     = S_RST;
            m_retry = 0;
        end else begin
            case (m_st)
                S_RST: if (m_age + 1 >= P_RST) nxt = S_WAIT;
                S_WAIT, S_STAB: begin
                    if (m_since + 1 >= P_TO) to = 1'b1;
                    else if (m_st == S_WAIT && ls != 0) nxt = S_STAB;
                    else if (m_st == S_STAB && ls == 0) nxt = S_WAIT;
                    else if (m_st == S_STAB && m_age + 1 >= P_STAB) nxt = S_REL;
                end
                S_REL: begin
                    if (ls == 0) lost = 1'b1;
                    else if (m_age + 1 >= P_REL) nxt = S_RUN;
                end
                S_RUN: if (m_lo_run >= P_LOSS) lost = 1'b1;
                default: ;
            endcase
            if (to) begin
                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                nxt     = (m_retry >= P_MAXR) ? S_FAIL : S_RST;
            end
            if (lost) begin
                m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                nxt    = S_RST;
            end
            if (nxt == S_RUN && m_st != S_RUN) m_retry = 0;
        end
        m_since = (m_st == S_RST) ? 0 : m_since + 1;
        m_age   = (nxt != m_st || rs) ? 0 : m_age + 1;
        m_st    = nxt;
    endtask

    always @(posedge clkin1) model_step(rst, restart, pll_lock);

    always @(negedge clkin1) begin
        logic [5:0] e;
        logic [5:0] a;
        if (chk_en) begin
            e = exp_outs(m_st);
            a = {pll_pwd, pll_rst, rstodiv, sys_rst, ready, fail};
            vectors++;
            if (a !== e || state !== 3'(m_st) || retry_cnt !== 4'(m_retry) || loss_cnt !== 8'(m_loss)) begin
                miscompares++;
                $display("FAIL model t=%0t state got %0d want %0d, outs got %b want %b, retry got %0d want %0d, loss got %0d want %0d",
                         $time, state, m_st, a, e, retry_cnt, m_retry, loss_cnt, m_loss);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clkin1);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready(input bit v);
        int n;
        n = 0;
        while (ready !== v && n < 200) begin
            tick(1);
            n++;
        end
        check("wait_ready", int'(ready), int'(v));
    endtask

    initial begin
        rst = 1'b1;
        tick(3);
        chk_en = 1'b1;
        check("rst state", state, S_RST);
        check("rst pll_rst", pll_rst, 1);
        check("rst sys_rst", sys_rst, 1);
        check("rst pll_pwd", pll_pwd, 0);

        // Clean bring-up.
        rst = 1'b0;
        tick(3);
        check("pll_rst held", pll_rst, 1);
        tick(1);
        check("pll_rst released", pll_rst, 0);
        tick(5);
        pll_lock = 1'b1;
        tick(10);
        check("rstodiv t+9", rstodiv, 1);
        tick(1);
        check("rstodiv t+10", rstodiv, 0);
        tick(3);
        check("ready t+13", ready, 0);
        tick(1);
        check("ready t+14", ready, 1);
        check("sys_rst t+14", sys_rst, 0);
        check("retry after run", retry_cnt, 0);

        // Loss filter in RUN: 2-cycle dip ignored, 3-cycle dip is a loss.
        tick(2);
        pll_lock = 1'b0;
        tick(2);
        pll_lock = 1'b1;
        tick(4);
        check("short dip ready", ready, 1);
        check("short dip loss", loss_cnt, 0);
        pll_lock = 1'b0;
        tick(3);
        pll_lock = 1'b1;
        tick(1);
        check("dip3 before", ready, 1);
        tick(1);
        check("dip3 ready", ready, 0);
        check("dip3 sys_rst", sys_rst, 1);
        check("dip3 pll_rst", pll_rst, 1);
        check("dip3 loss", loss_cnt, 1);

        // Glitch during STABLE restarts qualification.
        restart  = 1'b1;
        pll_lock = 1'b0;
        tick(1);
        restart = 1'b0;
        tick(6);
        pll_lock = 1'b1;
        tick(6);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(1);
        check("glitch t+7 state", state, S_STAB);
        tick(1);
        check("glitch t+8 state", state, S_WAIT);
        tick(8);
        check("requal t+16 rstodiv", rstodiv, 1);
        tick(1);
        check("requal t+17 state", state, S_REL);

        // Lock drop in RELEASE.
        pll_lock = 1'b0;
        tick(2);
        check("rel drop sys_rst", sys_rst, 1);
        tick(1);
        check("rel drop state", state, S_RST);
        check("rel drop loss", loss_cnt, 2);

        // Lock never asserts: one retry, then FAIL.
        tick(67);
        check("to1 pre pll_rst", pll_rst, 0);
        tick(1);
        check("to1 pll_rst", pll_rst, 1);
        check("to1 retry", retry_cnt, 1);
        tick(67);
        check("to2 pre fail", fail, 0);
        tick(1);
        check("to2 fail", fail, 1);
        check("to2 pwd", pll_pwd, 1);
        check("to2 retry", retry_cnt, 2);
        tick(5);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("restart state", state, S_RST);
        check("restart retry", retry_cnt, 0);
        check("restart fail", fail, 0);

        // Random lock traffic with occasional restart/rst.
        for (int i = 0; i < 3000;) begin
            int len;
            pll_lock = ($urandom_range(0, 9) < 8);
            len = pll_lock ? $urandom_range(1, 40) : $urandom_range(1, 5);
            if (!pll_lock && $urandom_range(0, 7) == 0) len = 150;
            for (int j = 0; j < len; j++) begin
                restart = ($urandom_range(0, 299) == 0);
                rst     = ($urandom_range(0, 999) == 0);
                tick(1);
                i++;
            end
        end
        rst     = 1'b0;
        restart = 1'b0;

        // rst mid-RUN.
        pll_lock = 1'b1;
        wait_ready(1'b1);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrun rst state", state, S_RST);
        check("midrun rst loss", loss_cnt, 0);
        check("midrun rst ready", ready, 0);
        check("midrun rst rstodiv", rstodiv, 1);

        // Loss counter saturation.
        wait_ready(1'b1);
        for (int k = 0; k < 300; k++) begin
            pll_lock = 1'b0;
            wait_ready(1'b0);
            pll_lock = 1'b1;
            wait_ready(1'b1);
        end
        check("loss saturate", loss_cnt, 255);

        tick(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
